// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words from instruction memory into a
// small circular FIFO of {instruction, pc+4}, with redirect flushing and stale-response drop.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        consume,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        o_valid,
    output logic [31:0] o_com,
    output logic [31:0] o_pc_plus4,
    output logic [3:0]  o_count
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t         state, state_next;
    logic [31:0]    fetch_pc, fetch_pc_next;
    logic [31:0]    addr_next;
    logic [31:0]    addr_plus4;
    logic [3:0]     count, count_next;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic           push, pop;

    logic [31:0]    mem_instr [DEPTH];
    logic [31:0]    mem_pc4   [DEPTH];

    assign addr_plus4 = imem_addr + 32'd4;

    // Redirect wins over both queue operations.
    assign push       = (state == S_WAIT) && imem_ack && !redirect;
    assign pop        = consume && o_valid && !redirect;
    assign count_next = count + {3'b000, push} - {3'b000, pop};

    assign imem_req   = (state != S_IDLE);
    assign o_valid    = (count != 4'd0);
    assign o_count    = count;
    assign o_com      = o_valid ? mem_instr[rd_ptr] : 32'h0;
    assign o_pc_plus4 = o_valid ? mem_pc4[rd_ptr]   : 32'h0;

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_next    = state;
        addr_next     = imem_addr;
        fetch_pc_next = fetch_pc;
        if (redirect) begin
            fetch_pc_next = redirect_pc & 32'hFFFF_FFFC;
        end
        unique case (state)
            S_IDLE: begin
                if (!redirect && (count_next < DEPTH_C)) begin
                    state_next = S_WAIT;
                    addr_next  = fetch_pc;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_next = imem_ack ? S_IDLE : S_DROP;
                end else if (imem_ack) begin
                    fetch_pc_next = addr_plus4;
                    if (count_next < DEPTH_C) begin
                        addr_next = addr_plus4;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                // The stale response is swallowed; only fetch_pc tracks new redirects.
                if (imem_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            imem_addr <= 32'h0;
            count     <= 4'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            imem_addr <= addr_next;
            if (redirect) begin
                count  <= 4'd0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                count <= count_next;
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // NOTE: storage is not reset; the head is masked by o_valid, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= imem_data;
            mem_pc4[wr_ptr]   <= addr_plus4;
        end
    end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning queue entries (power of two, 2..8).
REQ-002 Parameter RESET_PC, default 32'h0, meaning first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 redirect  input  1  taken branch/jump from the EX/MEM stage; restart fetch at redirect_pc.
REQ-006 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-007 consume  input  1  decode accepts the head entry this cycle.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  32  fetch address, word aligned.
REQ-010 imem_ack  input  1  instruction memory returns data this cycle.
REQ-011 imem_data  input  32  fetched instruction, valid when imem_ack=1.
REQ-012 o_valid  output  1  head entry present.
REQ-013 o_com  output  32  head instruction (show-ahead).
REQ-014 o_pc_plus4  output  32  head fetch address + 4.
REQ-015 o_count  output  4  number of occupied entries, 0..DEPTH.

Function
REQ-016 The block SHALL be a circular FIFO of {instruction, pc_plus4} with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-017 The block SHALL run an FSM with states IDLE, WAIT, DROP and allow at most one outstanding request.
REQ-018 IDLE: if redirect=0 and count_next<DEPTH, the block SHALL go to WAIT, latching imem_addr=fetch_pc; otherwise stay in IDLE.
REQ-019 count_next SHALL equal count + push - pop for the current cycle.
REQ-020 In WAIT and DROP, imem_req SHALL be 1 and imem_addr SHALL be held stable until imem_ack=1.
REQ-021 imem_req SHALL be 0 in IDLE.
REQ-022 WAIT with imem_ack=1 and redirect=0: the block SHALL push {imem_data, imem_addr+4} and set fetch_pc=imem_addr+4.
REQ-023 After that push, if count_next<DEPTH the block SHALL stay in WAIT with imem_addr=fetch_pc+4 (back-to-back, one instruction per cycle); otherwise it SHALL go to IDLE.
REQ-024 A request is issued only when a slot is free, so the response SHALL never arrive to a full queue.
REQ-025 pop SHALL occur when consume=1 and o_valid=1; consume with o_valid=0 SHALL be ignored.
REQ-026 Simultaneous push and pop SHALL leave count unchanged.
REQ-027 o_valid SHALL be (count!=0); o_com and o_pc_plus4 SHALL show the head entry combinationally from storage.
REQ-028 Redirect SHALL have priority over push and pop: queue emptied (count=0, pointers=0) and fetch_pc=redirect_pc.
REQ-029 Redirect in WAIT without ack SHALL go to DROP.
REQ-030 Redirect with ack in the same cycle SHALL discard the data and go to IDLE.
REQ-031 Redirect in IDLE SHALL stay in IDLE.
REQ-032 DROP: the block SHALL keep the stale request until imem_ack=1, discard the data, then go to IDLE.
REQ-033 A redirect during DROP SHALL update fetch_pc only.
REQ-034 Address arithmetic SHALL be 32-bit modulo 2^32 (32'hFFFFFFFC + 4 = 0).
REQ-035 Bits [1:0] of redirect_pc SHALL be forced to 0.

Reset
REQ-036 While rst=0, the block SHALL force: state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, imem_req=0, imem_addr=0, o_valid=0, o_com=0, o_pc_plus4=0, o_count=0.
REQ-037 Reset mid-WAIT/DROP SHALL abandon the request without a response being pushed.
REQ-038 The first request SHALL be issued on the second rising edge after rst deasserts.

Verification
REQ-039 Zero-latency memory (ack in the same cycle as req), consume=1 always -> o_pc_plus4 = 4, 8, 12, ... one per cycle, o_count <= 1.
REQ-040 consume=0, memory returns 0x11,0x22,0x33,0x44,0x55 -> o_count saturates at 4, imem_req=0 afterwards, then consume pulses pop 0x11..0x44 in order and a fresh fetch of address 16 follows.
REQ-041 Redirect to 0x100 while WAIT on address 8 with ack 3 cycles later -> ack data discarded, o_valid=0, next request address 0x100, first new head o_pc_plus4=0x104.
REQ-042 Redirect to 0x200 in the same cycle as ack and consume at count=2 -> count=0 next cycle, imem_addr 0x200 issued.
REQ-043 rst=0 asserted mid-WAIT with 3 entries queued -> all outputs 0 immediately; after release the first fetch address is RESET_PC.
REQ-044 Redirect to 0xFFFFFFFC, two acks -> o_pc_plus4 = 0x00000000 then 0x00000004.
